dst_track_fwd: RTL and testbench

//  Tracks the write-destination register number (from the 5-bit RegDst mux in EX) through the
//  EX->MEM->WB pipeline slots. Generates ALU-operand forwarding selects for the EX stage and a

---
 rtl/dst_track_fwd_pkg.sv | 12 +
 rtl/dst_slot_reg.sv | 22 ++
 rtl/dst_track_fwd.sv | 92 +++++++++
 tb/tb_dst_track_fwd.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dst_track_fwd_pkg.sv
// Shared constants for destination tracking and ALU operand forwarding.
// Forwarding-select encodings and register-number geometry.
package dst_track_fwd_pkg;

  localparam int AW       = 5;
  localparam int REG_ZERO = 0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/dst_slot_reg.sv
// One pipeline slot holding {dst, regwrite}; async reset, hold enable, sync clear.
// Hold wins over clear so a frozen pipeline never loses a slot to a squash.
module dst_slot_reg #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/dst_track_fwd.sv
// Tracks EX write destinations through MEM/WB, produces EX operand forwarding
// selects, the ID load-use stall request and a saturating stall-cycle counter.
module dst_track_fwd #(
  parameter int AW   = dst_track_fwd_pkg::AW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            ex_flush,
  input  logic [AW-1:0]   ex_dst,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [AW-1:0]   ex_rs,
  input  logic [AW-1:0]   ex_rt,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_use_rt,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            load_use,
  output logic [AW-1:0]   mem_dst,
  output logic            mem_regwrite,
  output logic [AW-1:0]   wb_dst,
  output logic            wb_regwrite,
  output logic [CNTW-1:0] stall_cnt
);

  import dst_track_fwd_pkg::*;

  logic          ex_dst_nz;
  logic [AW:0]   mem_d;
  logic [AW:0]   mem_q;
  logic [AW:0]   wb_q;

  assign ex_dst_nz = (ex_dst != AW'(REG_ZERO));

  // Register 0 is never marked valid, so a zero source can never forward.
  assign mem_d = {ex_dst, ex_regwrite & ex_dst_nz};

  dst_slot_reg #(.W(AW+1)) u_mem_slot (
    .clk  (clk),
    .rst  (rst),
    .hold (freeze),
    .clr  (ex_flush),
    .d    (mem_d),
    .q    (mem_q)
  );

  dst_slot_reg #(.W(AW+1)) u_wb_slot (
    .clk  (clk),
    .rst  (rst),
    .hold (freeze),
    .clr  (1'b0),
    .d    (mem_q),
    .q    (wb_q)
  );

  assign mem_dst      = mem_q[AW:1];
  assign mem_regwrite = mem_q[0];
  assign wb_dst       = wb_q[AW:1];
  assign wb_regwrite  = wb_q[0];

  // MEM holds the younger result, so it takes priority over WB.
  always_comb begin
    fwd_a = FWD_RF;
    if (mem_regwrite && (mem_dst == ex_rs)) begin
      fwd_a = FWD_MEM;
    end else if (wb_regwrite && (wb_dst == ex_rs)) begin
      fwd_a = FWD_WB;
    end

    fwd_b = FWD_RF;
    if (mem_regwrite && (mem_dst == ex_rt)) begin
      fwd_b = FWD_MEM;
    end else if (wb_regwrite && (wb_dst == ex_rt)) begin
      fwd_b = FWD_WB;
    end
  end

  assign load_use = ex_memread & ex_regwrite & ex_dst_nz & ~ex_flush &
                    ((ex_dst == id_rs) | (id_use_rt & (ex_dst == id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!freeze && load_use && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dst_track_fwd.sv
// Scoreboard bench for dst_track_fwd: driver predicts each cycle from a queue
// model of in-flight writes, monitor compares on the falling edge.
module tb_dst_track_fwd;

  localparam int AW   = 5;
  localparam int CNTW = 6;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            freeze;
  logic            ex_flush;
  logic [AW-1:0]   ex_dst;
  logic            ex_regwrite;
  logic            ex_memread;
  logic [AW-1:0]   ex_rs;
  logic [AW-1:0]   ex_rt;
  logic [AW-1:0]   id_rs;
  logic [AW-1:0]   id_rt;
  logic            id_use_rt;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            load_use;
  logic [AW-1:0]   mem_dst;
  logic            mem_regwrite;
  logic [AW-1:0]   wb_dst;
  logic            wb_regwrite;
  logic [CNTW-1:0] stall_cnt;

  dst_track_fwd #(.AW(AW), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .ex_flush     (ex_flush),
    .ex_dst       (ex_dst),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rt    (id_use_rt),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .load_use     (load_use),
    .mem_dst      (mem_dst),
    .mem_regwrite (mem_regwrite),
    .wb_dst       (wb_dst),
    .wb_regwrite  (wb_regwrite),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dst;
    bit we;
  } wr_t;

  typedef struct {
    int mem_dst;
    int mem_we;
    int wb_dst;
    int wb_we;
    int fa;
    int fb;
    int lu;
    int cnt;
  } exp_t;

  exp_t expq[$];
  wr_t  pipe[$];      // in-flight writes, youngest first: [0]=MEM, [1]=WB
  int   cnt_m;
  int   checks   = 0;
  int   failures = 0;
  bit   started  = 0;
  bit   done     = 0;

  // stimulus seen by the DUT at the upcoming edge
  bit p_rst, p_freeze, p_flush, p_rw, p_lu;
  int p_dst;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int fwd_sel(input int src);
    for (int k = 0; k < 2; k++) begin
      if (pipe[k].we && pipe[k].dst == src) return (k == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  task automatic clear_model();
    wr_t b;
    b.dst = 0;
    b.we  = 0;
    pipe  = {b, b};
    cnt_m = 0;
  endtask

  task automatic step(input bit r, input bit fz, input bit fl, input int dst,
                      input bit rw, input bit mr, input int ers, input int ert,
                      input int irs, input int irt, input bit iut);
    wr_t  n;
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    if (!p_rst && !p_freeze) begin
      n.dst = p_flush ? 0 : p_dst;
      n.we  = !p_flush && p_rw && (p_dst != 0);
      pipe.push_front(n);
      void'(pipe.pop_back());
      if (p_lu && cnt_m < CMAX) cnt_m++;
    end
    rst         = r;
    freeze      = fz;
    ex_flush    = fl;
    ex_dst      = dst[AW-1:0];
    ex_regwrite = rw;
    ex_memread  = mr;
    ex_rs       = ers[AW-1:0];
    ex_rt       = ert[AW-1:0];
    id_rs       = irs[AW-1:0];
    id_rt       = irt[AW-1:0];
    id_use_rt   = iut;
    if (r) clear_model();
    lu = mr && rw && (dst != 0) && !fl && ((dst == irs) || (iut && dst == irt));
    e.mem_dst = pipe[0].dst;
    e.mem_we  = int'(pipe[0].we);
    e.wb_dst  = pipe[1].dst;
    e.wb_we   = int'(pipe[1].we);
    e.fa      = fwd_sel(ers);
    e.fb      = fwd_sel(ert);
    e.lu      = int'(lu);
    e.cnt     = cnt_m;
    expq.push_back(e);
    p_rst = r; p_freeze = fz; p_flush = fl; p_rw = rw; p_dst = dst; p_lu = lu;
    started = 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (started && !done) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty got=0 expected=1 at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("mem_dst",      int'(mem_dst),      e.mem_dst);
        chk("mem_regwrite", int'(mem_regwrite), e.mem_we);
        chk("wb_dst",       int'(wb_dst),       e.wb_dst);
        chk("wb_regwrite",  int'(wb_regwrite),  e.wb_we);
        chk("fwd_a",        int'(fwd_a),        e.fa);
        chk("fwd_b",        int'(fwd_b),        e.fb);
        chk("load_use",     int'(load_use),     e.lu);
        chk("stall_cnt",    int'(stall_cnt),    e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; freeze = 0; ex_flush = 0; ex_dst = '0; ex_regwrite = 0; ex_memread = 0;
    ex_rs = '0; ex_rt = '0; id_rs = '0; id_rt = '0; id_use_rt = 0;
    clear_model();
    p_rst = 1; p_freeze = 0; p_flush = 0; p_rw = 0; p_dst = 0; p_lu = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // back-to-back ALU forwarding from MEM then WB
    step(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    // double match resolves to MEM
    step(0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0);
    // writes to register zero never become valid
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use: rt hazard, rt not used, flushed load
    step(0, 0, 0, 9, 1, 1, 0, 0, 3, 9, 1);
    step(0, 0, 0, 9, 1, 1, 0, 0, 3, 9, 0);
    step(0, 0, 1, 9, 1, 1, 0, 0, 9, 9, 1);
    step(0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 0);
    // freeze with changing inputs, including a hazard
    step(0, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 12, 1, 0, 11, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, i[0], 13 + i, 1, 1, 12, 11, 13 + i, 0, 0);
    step(0, 0, 0, 0, 0, 0, 12, 11, 0, 0, 0);
    // drive the counter into saturation, then hold under freeze
    for (int i = 0; i < CMAX + 6; i++)
      step(0, 0, 0, 14, 1, 1, 0, 0, 14, 0, 0);
    step(0, 1, 0, 14, 1, 1, 0, 0, 14, 0, 0);
    step(0, 0, 0, 14, 1, 1, 0, 0, 0, 14, 1);
    // reset mid-run with valid slots
    step(0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 6, 1, 0, 4, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 6, 4, 0, 0, 0);
    step(1, 0, 0, 8, 1, 0, 6, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 6, 4, 0, 0, 0);

    // randomized traffic over a small register set so matches are frequent
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    #1;
    done = 1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
